rr_grant_ctrl32: RTL and testbench

- Round-robin arbiter sharing one resource among 32 requesters.
- Registered winner kept as a 5-bit index; a 5-to-32 line decoder turns it into a one-hot grant that drives per-requester select lines.
- Adds hold/release handshake, a hold-time watchdog and a one-cycle turnaround gap between owners.

---
 rtl/rr_grant_ctrl32_pkg.sv | 18 +
 rtl/rr_grant_ctrl32_idx_decoder32.sv | 19 +
 rtl/rr_grant_ctrl32.sv | 116 +++++++++++
 tb/tb_rr_grant_ctrl32.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rr_grant_ctrl32_pkg.sv
// Shared constants and types for the 32-way round-robin grant controller.
// Sizing, state encoding and the hold-counter terminal compare live here.
package rr_grant_ctrl32_pkg;

   localparam int N_REQ = 32;
   localparam int IDX_W = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // True on the last cycle an owner may keep the grant (terminal count).
   function automatic logic hold_expired(input logic [7:0] hold_cnt, input int max_hold);
      return (int'(hold_cnt) == (max_hold - 1));
   endfunction

endpackage

// File: rtl/rr_grant_ctrl32_idx_decoder32.sv
// Combinational 5-to-32 one-hot line decoder with enable.
// Also used as the line-select decoder in the datapath.
module idx_decoder32
   import rr_grant_ctrl32_pkg::*;
(
   input  logic             enable,
   input  logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   localparam logic [N_REQ-1:0] LSB_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   always_comb begin
      onehot = '0;
      if (enable)
         onehot = LSB_ONE << idx;
   end

endmodule

// File: rtl/rr_grant_ctrl32.sv
// Round-robin arbiter for 32 requesters with release handshake, hold-time
// watchdog and a mandatory one-cycle idle gap between owners.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; pick next winner searching from ptr upward
// ST_BUSY | gnt_idx owns the resource; hold_cnt counts owned cycles
module rr_grant_ctrl32
   import rr_grant_ctrl32_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             release_req,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state, state_n;
   logic [IDX_W-1:0] ptr, ptr_n;
   logic [IDX_W-1:0] idx_n;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
   logic             timeout_n;

   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic [IDX_W-1:0]   first_off;
   logic [IDX_W-1:0]   winner;
   logic               owner_req;
   logic               grant_end;

   // Rotate so that bit 0 corresponds to ptr, take the lowest set bit,
   // then map the offset back to an absolute index (mod 32 by width).
   always_comb begin
      req_dbl   = {req, req} >> ptr;
      req_rot   = req_dbl[N_REQ-1:0];
      first_off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_rot[i])
            first_off = IDX_W'(i);
      end
      winner = first_off + ptr;
   end

   assign owner_req = req[gnt_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gnt_idx  <= '0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_cnt_n;
         gnt_idx  <= idx_n;
         timeout  <= timeout_n;
      end
   end

   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      hold_cnt_n = hold_cnt;
      idx_n      = gnt_idx;
      timeout_n  = 1'b0;
      grant_end  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|req) begin
               state_n    = ST_BUSY;
               idx_n      = winner;
               hold_cnt_n = '0;
            end
         end
         ST_BUSY: begin
            hold_cnt_n = hold_cnt + CNT_W'(1);
            // A voluntary end wins over the watchdog when both hit together.
            if (release_req || !owner_req) begin
               grant_end = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               grant_end = 1'b1;
               timeout_n = 1'b1;
            end
            if (grant_end) begin
               state_n    = ST_IDLE;
               idx_n      = '0;
               ptr_n      = gnt_idx + IDX_W'(1);
               hold_cnt_n = '0;
            end
         end
         default: begin
            state_n = ST_IDLE;
            idx_n   = '0;
         end
      endcase
   end

   assign gnt_valid = (state == ST_BUSY);

   idx_decoder32 u_dec (
      .enable (gnt_valid),
      .idx    (gnt_idx),
      .onehot (gnt_onehot)
   );

endmodule

// File: tb/tb_rr_grant_ctrl32.sv
// Directed self-checking bench for rr_grant_ctrl32 (MAX_HOLD=16).
module tb_rr_grant_ctrl32;

   logic        clk;
   logic        rst;
   logic [31:0] req;
   logic        release_req;
   logic        gnt_valid;
   logic [4:0]  gnt_idx;
   logic [31:0] gnt_onehot;
   logic        timeout;

   int total = 0;
   int bad   = 0;

   rr_grant_ctrl32 #(.MAX_HOLD(16), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .release_req (release_req),
      .gnt_valid   (gnt_valid),
      .gnt_idx     (gnt_idx),
      .gnt_onehot  (gnt_onehot),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL sim_time_limit observed=running expected=finished");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_grant(input string tag, input logic [4:0] idx);
      chk({tag, "_valid"}, 32'(gnt_valid), 32'd1);
      chk({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
      chk({tag, "_onehot"}, gnt_onehot, 32'd1 << idx);
   endtask

   task automatic chk_idle(input string tag, input logic to_exp);
      chk({tag, "_valid"}, 32'(gnt_valid), 32'd0);
      chk({tag, "_idx"}, 32'(gnt_idx), 32'd0);
      chk({tag, "_onehot"}, gnt_onehot, 32'd0);
      chk({tag, "_timeout"}, 32'(timeout), 32'(to_exp));
   endtask

   logic [4:0] rot_exp [5];

   initial begin
      rst = 1'b1;
      req = '0;
      release_req = 1'b0;
      #2;
      chk_idle("reset_init", 1'b0);
      tick(2);
      rst = 1'b0;
      tick(1);
      chk_idle("idle_no_req", 1'b0);

      // single requester, ptr=0
      req = 32'h0000_0001;
      tick(1);
      chk_grant("single_grant", 5'd0);
      tick(1);
      chk_grant("single_hold", 5'd0);
      release_req = 1'b1;
      tick(1);
      chk_idle("single_release", 1'b0);
      release_req = 1'b0;
      req = '0;
      tick(1);

      // rotation with wrap; ptr=1 after owner 0
      rot_exp[0] = 5'd1;
      rot_exp[1] = 5'd31;
      rot_exp[2] = 5'd0;
      rot_exp[3] = 5'd1;
      rot_exp[4] = 5'd31;
      req = 32'h8000_0003;
      for (int k = 0; k < 5; k++) begin
         tick(1);
         chk_grant("rot_grant", rot_exp[k]);
         release_req = 1'b1;
         tick(1);
         chk_idle("rot_gap", 1'b0);
         release_req = 1'b0;
      end
      req = '0;
      tick(1);

      // watchdog, lone requester 5 (ptr=0 after owner 31)
      req = 32'h0000_0020;
      for (int i = 0; i < 16; i++) begin
         tick(1);
         chk_grant("wd_hold", 5'd5);
         chk("wd_hold_timeout", 32'(timeout), 32'd0);
      end
      tick(1);
      chk_idle("wd_revoke", 1'b1);
      tick(1);
      chk_grant("wd_regrant", 5'd5);
      chk("wd_regrant_timeout", 32'(timeout), 32'd0);

      // watchdog with competitor 8 arriving during the grant
      req = 32'h0000_0120;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         chk_grant("wdc_hold", 5'd5);
      end
      tick(1);
      chk_idle("wdc_revoke", 1'b1);
      tick(1);
      chk_grant("wdc_next", 5'd8);

      // release coinciding with terminal count
      for (int i = 0; i < 15; i++) begin
         tick(1);
         chk_grant("coin_hold", 5'd8);
      end
      release_req = 1'b1;
      tick(1);
      chk_idle("coin_release", 1'b0);
      release_req = 1'b0;

      // ptr=9 now: search wraps to 5; then owner withdraws
      tick(1);
      chk_grant("wrap_pick", 5'd5);
      req = 32'h0000_0100;
      tick(1);
      chk_idle("withdraw", 1'b0);
      tick(1);
      chk_grant("after_withdraw", 5'd8);

      // other lines changing during BUSY do nothing
      req = 32'h0000_01F0;
      tick(1);
      chk_grant("busy_ignore", 5'd8);

      // async reset mid-grant
      req = 32'hFFFF_FFFF;
      tick(1);
      chk_grant("pre_reset", 5'd8);
      #3;
      rst = 1'b1;
      #1;
      chk_idle("async_reset", 1'b0);
      #1;
      rst = 1'b0;
      tick(1);
      chk_grant("post_reset", 5'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
